// File: rtl/vq_search_pkg.sv
// Shared widths, FSM state type and counter-width helper for the VQ codebook search controller.
package vq_search_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 14;
    localparam int DEF_VEC_DIM    = 13;
    localparam int DEF_NUM_CW     = 16;
    localparam int DEF_ACC_WIDTH  = 2 * DEF_DATA_WIDTH + 2 + $clog2(DEF_VEC_DIM);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SCAN  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } vq_state_e;

    // A counter over n values needs at least one bit even when n == 1.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_DIM_W = cnt_width(DEF_VEC_DIM);
    localparam int DEF_CW_W  = cnt_width(DEF_NUM_CW);

endpackage

// File: rtl/vq_sqdiff_stage.sv
// First datapath stage: signed feature-minus-codeword difference, squared, with tag passthrough.
module vq_sqdiff_stage
    import vq_search_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CW_W       = DEF_CW_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vld_i,
    input  logic                         first_i,
    input  logic                         last_i,
    input  logic        [CW_W-1:0]       cw_i,
    input  logic signed [DATA_WIDTH-1:0] feat_i,
    input  logic signed [DATA_WIDTH-1:0] rom_i,
    output logic                         vld_p1_o,
    output logic                         first_p1_o,
    output logic                         last_p1_o,
    output logic        [CW_W-1:0]       cw_p1_o,
    output logic        [2*DATA_WIDTH+1:0] sq_p1_o
);

    localparam int SQ_W = 2 * DATA_WIDTH + 2;

    function automatic logic [SQ_W-1:0] square(input logic signed [DATA_WIDTH:0] d);
        logic signed [SQ_W-1:0] dx;
        dx = {{(SQ_W-DATA_WIDTH-1){d[DATA_WIDTH]}}, d};
        return $unsigned(dx * dx);
    endfunction

    logic signed [DATA_WIDTH:0] diff_p0;
    logic                       vld_p1;
    logic                       first_p1;
    logic                       last_p1;
    logic        [CW_W-1:0]     cw_p1;
    logic        [SQ_W-1:0]     sq_p1;

    // One extra bit keeps the difference of two full-range samples exact.
    assign diff_p0 = {feat_i[DATA_WIDTH-1], feat_i} - {rom_i[DATA_WIDTH-1], rom_i};

    // ---- stage p0 -> p1 ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_i;
        end
    end

    always_ff @(posedge clk) begin
        first_p1 <= first_i;
        last_p1  <= last_i;
        cw_p1    <= cw_i;
        sq_p1    <= square(diff_p0);
    end

    assign vld_p1_o   = vld_p1;
    assign first_p1_o = first_p1;
    assign last_p1_o  = last_p1;
    assign cw_p1_o    = cw_p1;
    assign sq_p1_o    = sq_p1;

endmodule

// File: rtl/vq_codebook_search_ctrl.sv
// Full-search nearest-codeword controller: loads one feature vector, walks the codebook ROM,
// and reports the index and squared-Euclidean distortion of the closest codeword.
module vq_codebook_search_ctrl
    import vq_search_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int VEC_DIM    = DEF_VEC_DIM,
    parameter int NUM_CW     = DEF_NUM_CW,
    parameter int CW_BASE    = 0,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + 2 + $clog2(VEC_DIM)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             feat_valid,
    output logic                             feat_ready,
    input  logic signed [DATA_WIDTH-1:0]     feat_data,
    output logic        [ADDR_WIDTH-1:0]     rom_addr,
    input  logic signed [DATA_WIDTH-1:0]     rom_rd_data,
    output logic                             busy,
    output logic                             res_valid,
    output logic        [cnt_width(NUM_CW)-1:0] best_idx,
    output logic        [ACC_WIDTH-1:0]      best_dist
);

    localparam int DIM_W = cnt_width(VEC_DIM);
    localparam int CW_W  = cnt_width(NUM_CW);
    localparam int SQ_W  = 2 * DATA_WIDTH + 2;
    localparam int WORDS = NUM_CW * VEC_DIM;

    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(CW_BASE);
    localparam logic [ADDR_WIDTH-1:0] PENULT_ADDR = ADDR_WIDTH'(CW_BASE + WORDS - 2);
    localparam logic [DIM_W-1:0]      DIM_LAST    = DIM_W'(VEC_DIM - 1);

    if (CW_BASE + WORDS > (1 << ADDR_WIDTH)) begin : g_bad_rom_range
        $error("codebook does not fit in the ROM address space");
    end
    if (WORDS < 2) begin : g_bad_words
        $error("codebook must hold at least two ROM words");
    end
    if (ACC_WIDTH < SQ_W + $clog2(VEC_DIM)) begin : g_bad_acc
        $error("ACC_WIDTH too narrow for worst-case distortion");
    end

    vq_state_e                   state_q;
    logic [DIM_W-1:0]            elem_cnt_q;
    logic [DIM_W-1:0]            dim_q;
    logic [CW_W-1:0]             cw_q;
    logic [ADDR_WIDTH-1:0]       rom_addr_q;
    logic                        flush_q;
    logic                        feat_ready_q;
    logic                        busy_q;
    logic                        res_valid_q;
    logic [CW_W-1:0]             best_idx_q;
    logic [ACC_WIDTH-1:0]        best_dist_q;
    logic signed [DATA_WIDTH-1:0] feat_mem [VEC_DIM];

    logic                        load_fire;
    logic                        dim_last;
    logic                        vld_p0;

    logic                        vld_p1;
    logic                        first_p1;
    logic                        last_p1;
    logic [CW_W-1:0]             cw_p1;
    logic [SQ_W-1:0]             sq_p1;

    logic [ACC_WIDTH-1:0]        acc_q;
    logic [ACC_WIDTH-1:0]        run_dist_q;
    logic [ACC_WIDTH-1:0]        run_dist_d;
    logic [CW_W-1:0]             run_idx_q;
    logic [CW_W-1:0]             run_idx_d;
    logic [ACC_WIDTH-1:0]        cand;
    logic                        take_best;

    assign load_fire = ((state_q == IDLE) || (state_q == LOAD)) && feat_valid && feat_ready_q;
    assign dim_last  = (dim_q == DIM_LAST);
    // The last ROM word is presented during the first FLUSH cycle, so stage p0 is still live there.
    assign vld_p0    = (state_q == SCAN) || ((state_q == FLUSH) && !flush_q);

    always_ff @(posedge clk) begin
        if (load_fire) begin
            feat_mem[elem_cnt_q] <= feat_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            elem_cnt_q   <= '0;
            dim_q        <= '0;
            cw_q         <= '0;
            rom_addr_q   <= BASE_ADDR;
            flush_q      <= 1'b0;
            feat_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            best_idx_q   <= '0;
            best_dist_q  <= '0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                IDLE, LOAD: begin
                    if (load_fire) begin
                        if (elem_cnt_q == DIM_LAST) begin
                            elem_cnt_q   <= '0;
                            state_q      <= SCAN;
                            feat_ready_q <= 1'b0;
                            busy_q       <= 1'b1;
                        end else begin
                            elem_cnt_q <= elem_cnt_q + 1'b1;
                            state_q    <= LOAD;
                        end
                    end
                end
                SCAN: begin
                    if (dim_last) begin
                        dim_q <= '0;
                        cw_q  <= cw_q + 1'b1;
                    end else begin
                        dim_q <= dim_q + 1'b1;
                    end
                    rom_addr_q <= rom_addr_q + 1'b1;
                    if (rom_addr_q == PENULT_ADDR) begin
                        state_q <= FLUSH;
                        flush_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (!flush_q) begin
                        flush_q <= 1'b1;
                        dim_q   <= '0;
                        cw_q    <= '0;
                    end else begin
                        flush_q     <= 1'b0;
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        res_valid_q <= 1'b1;
                        best_idx_q  <= run_idx_d;
                        best_dist_q <= run_dist_d;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    feat_ready_q <= 1'b1;
                    rom_addr_q   <= BASE_ADDR;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ---- stage p0 -> p1 ----
    vq_sqdiff_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .CW_W       (CW_W)
    ) u_sqdiff (
        .clk        (clk),
        .rst        (rst),
        .vld_i      (vld_p0),
        .first_i    (dim_q == '0),
        .last_i     (dim_last),
        .cw_i       (cw_q),
        .feat_i     (feat_mem[dim_q]),
        .rom_i      (rom_rd_data),
        .vld_p1_o   (vld_p1),
        .first_p1_o (first_p1),
        .last_p1_o  (last_p1),
        .cw_p1_o    (cw_p1),
        .sq_p1_o    (sq_p1)
    );

    // Strict less-than keeps the lowest index on ties; codeword 0 always seeds the search.
    always_comb begin
        cand       = (first_p1 ? '0 : acc_q) + ACC_WIDTH'(sq_p1);
        take_best  = vld_p1 && last_p1 && ((cw_p1 == '0) || (cand < run_dist_q));
        run_dist_d = take_best ? cand  : run_dist_q;
        run_idx_d  = take_best ? cw_p1 : run_idx_q;
    end

    // ---- stage p1 -> p2 ----
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            run_dist_q <= '0;
            run_idx_q  <= '0;
        end else begin
            if (vld_p1) begin
                acc_q <= cand;
            end
            run_dist_q <= run_dist_d;
            run_idx_q  <= run_idx_d;
        end
    end

    assign feat_ready = feat_ready_q;
    assign rom_addr   = rom_addr_q;
    assign busy       = busy_q;
    assign res_valid  = res_valid_q;
    assign best_idx   = best_idx_q;
    assign best_dist  = best_dist_q;

endmodule

// File: tb/tb_vq_codebook_search_ctrl.sv
// Directed bench for vq_codebook_search_ctrl with a behavioural combinational codebook ROM.
module tb_vq_codebook_search_ctrl;

    localparam int AW   = 8;
    localparam int DW   = 14;
    localparam int VD   = 13;
    localparam int NC   = 16;
    localparam int ACCW = 34;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 feat_valid = 1'b0;
    logic signed [DW-1:0] feat_data = '0;
    logic                 feat_ready;
    logic        [AW-1:0] rom_addr;
    logic signed [DW-1:0] rom_rd_data;
    logic                 busy;
    logic                 res_valid;
    logic        [3:0]    best_idx;
    logic      [ACCW-1:0] best_dist;

    logic signed [DW-1:0] rom [256];
    logic signed [DW-1:0] feat_vec [VD];

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    assign rom_rd_data = rom[rom_addr];

    vq_codebook_search_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .VEC_DIM    (VD),
        .NUM_CW     (NC),
        .CW_BASE    (0),
        .ACC_WIDTH  (ACCW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .feat_valid  (feat_valid),
        .feat_ready  (feat_ready),
        .feat_data   (feat_data),
        .rom_addr    (rom_addr),
        .rom_rd_data (rom_rd_data),
        .busy        (busy),
        .res_valid   (res_valid),
        .best_idx    (best_idx),
        .best_dist   (best_dist)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Codeword k, element d holds 100*k + d.
    task automatic fill_pattern();
        for (int a = 0; a < 256; a++) rom[a] = '0;
        for (int k = 0; k < NC; k++)
            for (int d = 0; d < VD; d++)
                rom[k*VD + d] = DW'(100*k + d);
    endtask

    task automatic feat_from_cw(input int k, input int offs);
        for (int d = 0; d < VD; d++) feat_vec[d] = DW'(100*k + d + offs);
    endtask

    // Returns after the edge that accepted the last element (edge T).
    task automatic load_vec(input string tag, input bit gaps, output int xfers);
        int e;
        int cyc;
        e = 0;
        cyc = 0;
        xfers = 0;
        while (e < VD && cyc < 200) begin
            @(negedge clk);
            feat_valid = !(gaps && (cyc % 2 == 1));
            feat_data  = feat_vec[e];
            if (feat_valid && feat_ready) begin
                e++;
                xfers++;
            end
            cyc++;
            @(posedge clk);
        end
        check({tag, "_load_done"}, e, VD);
    endtask

    // Cycle n is observed at the falling edge that follows edge T+n-1.
    task automatic watch_scan(input string tag, input int xfers_in,
                              input int exp_idx, input logic [63:0] exp_dist);
        int xfers, strobe_n, strobes, addr_bad, ready_bad, busy_bad, ea;
        logic [3:0]      idx_at;
        logic [ACCW-1:0] dist_at;
        xfers = xfers_in;
        strobe_n = -1;
        strobes = 0;
        addr_bad = 0;
        ready_bad = 0;
        busy_bad = 0;
        idx_at = '0;
        dist_at = '0;
        for (int n = 1; n <= 215; n++) begin
            @(negedge clk);
            if (n == 210) feat_valid = 1'b0;
            if (feat_valid && feat_ready) xfers++;
            ea = (n <= 208) ? n - 1 : ((n <= 210) ? 207 : 0);
            if (int'(rom_addr) != ea) addr_bad++;
            if (feat_ready != (n >= 211)) ready_bad++;
            if (busy != (n <= 209)) busy_bad++;
            if (res_valid) begin
                strobes++;
                if (strobe_n < 0) strobe_n = n;
            end
            if (n == 210) begin
                idx_at  = best_idx;
                dist_at = best_dist;
            end
        end
        check({tag, "_strobe_cycle"}, strobe_n, 210);
        check({tag, "_strobe_count"}, strobes, 1);
        check({tag, "_best_idx"}, idx_at, exp_idx);
        check({tag, "_best_dist"}, dist_at, exp_dist);
        check({tag, "_idx_hold"}, best_idx, exp_idx);
        check({tag, "_dist_hold"}, best_dist, exp_dist);
        check({tag, "_addr_seq_bad"}, addr_bad, 0);
        check({tag, "_ready_bad"}, ready_bad, 0);
        check({tag, "_busy_bad"}, busy_bad, 0);
        check({tag, "_transfers"}, xfers, VD);
    endtask

    task automatic do_run(input string tag, input bit gaps, input int exp_idx, input logic [63:0] exp_dist);
        int x;
        load_vec(tag, gaps, x);
        watch_scan(tag, x, exp_idx, exp_dist);
    endtask

    initial begin
        int x;
        int strobes;
        fill_pattern();
        feat_from_cw(0, 0);

        // Power-on reset, then a partial load interrupted by reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        feat_valid = 1'b1;
        feat_data  = 14'sd77;
        repeat (5) @(negedge clk);
        feat_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_feat_ready", feat_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_best_idx", best_idx, 0);
        check("rst_best_dist", best_dist, 0);

        // Exact match on codeword 5.
        feat_from_cw(5, 0);
        do_run("exact5", 1'b0, 5, 64'd0);

        // Feature one above codeword 5 in every element, loaded with valid toggling.
        feat_from_cw(5, 1);
        do_run("near5_gaps", 1'b1, 5, 64'd13);

        // Codewords 3 and 9 identical: lowest index wins.
        for (int d = 0; d < VD; d++) rom[9*VD + d] = rom[3*VD + d];
        feat_from_cw(3, 0);
        do_run("tie3_9", 1'b0, 3, 64'd0);

        // Full-scale opposite extremes: 13 * 16383^2.
        for (int a = 0; a < NC*VD; a++) rom[a] = 14'sd8191;
        for (int d = 0; d < VD; d++) feat_vec[d] = -14'sd8192;
        do_run("extreme", 1'b0, 0, 64'd3489234957);

        // Abort at SCAN cycle 100, then a clean search for codeword 2.
        fill_pattern();
        feat_from_cw(7, 0);
        load_vec("abort", 1'b0, x);
        repeat (99) @(posedge clk);
        @(negedge clk);
        feat_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        strobes = 0;
        repeat (260) begin
            @(negedge clk);
            if (res_valid) strobes++;
        end
        check("abort_no_strobe", strobes, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", feat_ready, 1);
        check("abort_best_dist", best_dist, 0);
        feat_from_cw(2, 0);
        do_run("after_abort2", 1'b0, 2, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
